// File: rtl/my_full_ip_v1_0.sv
// AXI4 full slave fronting a small word-addressed memory; one burst in flight at a time.
// Supports FIXED/INCR/WRAP bursts with byte strobes and combinational read data.
module my_full_ip_v1_0 #(
    parameter int C_S00_AXI_ID_WIDTH     = 4,
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 32,
    parameter int C_MEM_WORDS            = 64,
    parameter int C_S00_AXI_AWUSER_WIDTH = 1,
    parameter int C_S00_AXI_ARUSER_WIDTH = 1,
    parameter int C_S00_AXI_WUSER_WIDTH  = 1,
    parameter int C_S00_AXI_RUSER_WIDTH  = 1,
    parameter int C_S00_AXI_BUSER_WIDTH  = 1
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_areset,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_awid,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [7:0]                          s00_axi_awlen,
    input  logic [2:0]                          s00_axi_awsize,
    input  logic [1:0]                          s00_axi_awburst,
    input  logic [1:0]                          s00_axi_awlock,
    input  logic [3:0]                          s00_axi_awcache,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic [3:0]                          s00_axi_awqos,
    input  logic [3:0]                          s00_axi_awregion,
    input  logic [C_S00_AXI_AWUSER_WIDTH-1:0]   s00_axi_awuser,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wlast,
    input  logic [C_S00_AXI_WUSER_WIDTH-1:0]    s00_axi_wuser,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_bid,
    output logic [1:0]                          s00_axi_bresp,
    output logic [C_S00_AXI_BUSER_WIDTH-1:0]    s00_axi_buser,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_arid,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [7:0]                          s00_axi_arlen,
    input  logic [2:0]                          s00_axi_arsize,
    input  logic [1:0]                          s00_axi_arburst,
    input  logic [1:0]                          s00_axi_arlock,
    input  logic [3:0]                          s00_axi_arcache,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic [3:0]                          s00_axi_arqos,
    input  logic [3:0]                          s00_axi_arregion,
    input  logic [C_S00_AXI_ARUSER_WIDTH-1:0]   s00_axi_aruser,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_rid,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rlast,
    output logic [C_S00_AXI_RUSER_WIDTH-1:0]    s00_axi_ruser,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic [1:0]                          dbg_state_o
);

    localparam int IDX_W = $clog2(C_MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_WRESP = 2'd2, S_READ = 2'd3} state_e;

    state_e                          state_q, state_d;
    logic [C_S00_AXI_ID_WIDTH-1:0]   id_q;
    logic [C_S00_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                      len_q;
    logic [1:0]                      burst_q;
    logic [7:0]                      cnt_q;

    logic [31:0]                     mem_q [C_MEM_WORDS];

    logic [IDX_W-1:0]                idx;
    logic                            last_beat;
    logic                            aw_hs, ar_hs, w_hs, r_hs;
    logic [C_S00_AXI_ADDR_WIDTH-1:0] addr_inc, wrap_mask, addr_next;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Ready/valid outputs here are combinational from state so no input is ever dropped.
    assign aw_hs     = s00_axi_awvalid && s00_axi_awready;
    assign ar_hs     = s00_axi_arvalid && s00_axi_arready;
    assign w_hs      = s00_axi_wvalid  && s00_axi_wready;
    assign r_hs      = s00_axi_rvalid  && s00_axi_rready;

    assign idx       = addr_q[IDX_W+1:2];
    assign last_beat = (cnt_q == len_q);
    assign dbg_state_o = state_q;

    // WRAP window is (len+1)*4 bytes; legal wrap lengths make this a power of two.
    always_comb begin
        addr_inc  = addr_q + C_S00_AXI_ADDR_WIDTH'(4);
        wrap_mask = C_S00_AXI_ADDR_WIDTH'({len_q, 2'b11});
        case (burst_q)
            2'b00:   addr_next = addr_q;
            2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default: addr_next = addr_inc;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (aw_hs)      state_d = S_WRITE;
                else if (ar_hs) state_d = S_READ;
            end
            S_WRITE: if (w_hs && (last_beat || s00_axi_wlast)) state_d = S_WRESP;
            S_WRESP: if (s00_axi_bready) state_d = S_IDLE;
            S_READ:  if (r_hs && last_beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_awready = 1'b0;
        s00_axi_arready = 1'b0;
        s00_axi_wready  = 1'b0;
        s00_axi_bvalid  = 1'b0;
        s00_axi_bid     = '0;
        s00_axi_rvalid  = 1'b0;
        s00_axi_rid     = '0;
        s00_axi_rdata   = '0;
        s00_axi_rlast   = 1'b0;
        if (!s00_axi_areset) begin
            case (state_q)
                S_IDLE: begin
                    s00_axi_awready = s00_axi_awvalid;
                    s00_axi_arready = !s00_axi_awvalid && s00_axi_arvalid;
                end
                S_WRITE: s00_axi_wready = 1'b1;
                S_WRESP: begin
                    s00_axi_bvalid = 1'b1;
                    s00_axi_bid    = id_q;
                end
                S_READ: begin
                    s00_axi_rvalid = 1'b1;
                    s00_axi_rid    = id_q;
                    s00_axi_rdata  = C_S00_AXI_DATA_WIDTH'(mem_q[idx]);
                    s00_axi_rlast  = last_beat;
                end
                default: ;
            endcase
        end
    end

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;
    assign s00_axi_buser = '0;
    assign s00_axi_ruser = '0;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else if (aw_hs) begin
            id_q    <= s00_axi_awid;
            addr_q  <= s00_axi_awaddr;
            len_q   <= s00_axi_awlen;
            burst_q <= s00_axi_awburst;
            cnt_q   <= '0;
        end else if (ar_hs) begin
            id_q    <= s00_axi_arid;
            addr_q  <= s00_axi_araddr;
            len_q   <= s00_axi_arlen;
            burst_q <= s00_axi_arburst;
            cnt_q   <= '0;
        end else if (w_hs || r_hs) begin
            addr_q  <= addr_next;
            cnt_q   <= cnt_q + 8'd1;
        end
    end

    // Memory contents survive reset on purpose.
    always_ff @(posedge s00_axi_aclk) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (s00_axi_wstrb[b]) mem_q[idx][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awsize, s00_axi_awlock, s00_axi_awcache, s00_axi_awprot,
                             s00_axi_awqos, s00_axi_awregion, s00_axi_awuser, s00_axi_wuser,
                             s00_axi_arsize, s00_axi_arlock, s00_axi_arcache, s00_axi_arprot,
                             s00_axi_arqos, s00_axi_arregion, s00_axi_aruser};

endmodule

// File: tb/tb_my_full_ip_v1_0.sv
// Directed bench for my_full_ip_v1_0: memory model plus expected-read queue.
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_my_full_ip_v1_0;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp, dbg_state;
    logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
    logic [0:0]  awuser, aruser, wuser, buser, ruser;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_q [64];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];

    always #5 clk = ~clk;

    my_full_ip_v1_0 dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
        .s00_axi_awsize(awsize), .s00_axi_awburst(awburst), .s00_axi_awlock(awlock),
        .s00_axi_awcache(awcache), .s00_axi_awprot(awprot), .s00_axi_awqos(awqos),
        .s00_axi_awregion(awregion), .s00_axi_awuser(awuser), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
        .s00_axi_wuser(wuser), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_buser(buser),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
        .s00_axi_arsize(arsize), .s00_axi_arburst(arburst), .s00_axi_arlock(arlock),
        .s00_axi_arcache(arcache), .s00_axi_arprot(arprot), .s00_axi_arqos(arqos),
        .s00_axi_arregion(arregion), .s00_axi_aruser(aruser), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rlast(rlast), .s00_axi_ruser(ruser), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .dbg_state_o(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] size, base;
        size = (32'(len) + 1) * 4;
        base = a - (a % size);
        case (burst)
            2'b00:   return a;
            2'b10:   return base + ((a - base + 4) % size);
            default: return a + 4;
        endcase
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input int nbeats, input int b_stall, input bit with_ar);
        logic [31:0] a;
        @(negedge clk);
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
        awsize = 3'd2; awprot = $urandom_range(7, 0); awcache = $urandom_range(15, 0);
        if (with_ar) begin
            araddr = addr; arlen = 8'd0; arburst = 2'b01; arid = 4'hE; arvalid = 1'b1;
        end
        #1;
        chk("awready", 32'(awready), 32'd1);
        chk("arready_during_aw", 32'(arready), 32'd0);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1);
            #1;
            chk("wready", 32'(wready), 32'd1);
            chk("no_bvalid_in_write", 32'(bvalid), 32'd0);
            for (int b = 0; b < 4; b++)
                if (sbuf[i][b]) model_q[a[7:2]][b*8 +: 8] = wbuf[i][b*8 +: 8];
            a = nxt(a, len, burst);
            @(posedge clk); @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b0;
        for (int s = 0; s < b_stall; s++) begin
            #1;
            chk("bvalid_held", 32'(bvalid), 32'd1);
            chk("wready_off_in_wresp", 32'(wready), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        bready = 1'b1;
        #1;
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bid", 32'(bid), 32'(id));
        chk("bresp", 32'(bresp), 32'd0);
        @(posedge clk); @(negedge clk);
        bready = 1'b0;
        #1;
        chk("bvalid_cleared", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int stall_beat);
        logic [31:0] a, exp_d;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(model_q[a[7:2]]);
            a = nxt(a, len, burst);
        end
        @(negedge clk);
        araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
        arsize = $urandom_range(7, 0); arqos = $urandom_range(15, 0);
        #1;
        chk("arready", 32'(arready), 32'd1);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            if (i == stall_beat) begin
                rready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk("stall_rvalid", 32'(rvalid), 32'd1);
                    chk("stall_rdata", rdata, exp_d);
                    chk("stall_rlast", 32'(rlast), 32'(i == int'(len)));
                    @(posedge clk); @(negedge clk);
                end
                rready = 1'b1;
            end
            #1;
            chk("rvalid", 32'(rvalid), 32'd1);
            chk("rdata", rdata, exp_d);
            chk("rlast", 32'(rlast), 32'(i == int'(len)));
            chk("rid", 32'(rid), 32'(id));
            chk("rresp", 32'(rresp), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        rready = 1'b0;
        #1;
        chk("rvalid_cleared", 32'(rvalid), 32'd0);
    endtask

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = 2'b01; awlock = '0;
        awcache = '0; awprot = '0; awqos = '0; awregion = '0; awuser = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = 2'b01; arlock = '0;
        arcache = '0; arprot = '0; arqos = '0; arregion = '0; aruser = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset: requests are ignored and every output stays low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bid_rid", {bid, rid}, 32'd0);
        chk("rst_users", {buser, ruser}, 32'd0);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0; areset = 1'b0;
        #1;
        chk("idle_after_reset", 32'(dbg_state), 32'd0);

        // Single write/read.
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        axi_write(32'h0, 8'd0, 2'b01, 4'd3, 1, 0, 1'b0);
        axi_read(32'h0, 8'd0, 2'b01, 4'd9, -1);

        // INCR burst, then read with a 3-cycle rready stall on beat 1.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        axi_write(32'h10, 8'd3, 2'b01, 4'd1, 4, 0, 1'b0);
        axi_read(32'h10, 8'd3, 2'b01, 4'd2, 1);

        // WRAP read: 0x18,0x1C,0x10,0x14 -> 3,4,1,2.
        axi_read(32'h18, 8'd3, 2'b10, 4'd4, -1);

        // Byte strobes over a zeroed word.
        wbuf[0] = 32'h0; sbuf[0] = 4'hF;
        axi_write(32'h30, 8'd0, 2'b01, 4'd6, 1, 0, 1'b0);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h5;
        axi_write(32'h30, 8'd0, 2'b01, 4'd6, 1, 0, 1'b0);
        chk("strobe_model", model_q[12], 32'h00BB00DD);
        axi_read(32'h30, 8'd0, 2'b01, 4'd7, -1);

        // Simultaneous AW/AR with a held B response.
        wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
        axi_write(32'h34, 8'd0, 2'b01, 4'd8, 1, 3, 1'b1);
        axi_read(32'h34, 8'd0, 2'b01, 4'hE, -1);

        // FIXED burst keeps hitting the same word.
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(32'h40, 8'd1, 2'b00, 4'd2, 2, 0, 1'b0);
        axi_read(32'h40, 8'd1, 2'b00, 4'd2, -1);

        // Early wlast ends a len-3 burst after two beats.
        wbuf[0] = 32'h7; wbuf[1] = 32'h8;
        axi_write(32'h50, 8'd3, 2'b01, 4'd5, 2, 1, 1'b0);
        axi_read(32'h50, 8'd1, 2'b01, 4'd5, -1);

        // High address bits alias onto the same words.
        axi_read(32'h110, 8'd0, 2'b01, 4'd1, -1);

        // Reset during the 2nd beat of a len-3 write.
        @(negedge clk);
        awaddr = 32'h20; awlen = 8'd3; awburst = 2'b01; awid = 4'd5; awvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wlast = 1'b0;
        model_q[8] = 32'h11111111;
        @(posedge clk); @(negedge clk);
        wdata = 32'h22222222; areset = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        chk("midrst_wready", 32'(wready), 32'd0);
        chk("midrst_valids", {awready, arready, bvalid, rvalid, rlast}, 32'd0);
        areset = 1'b0; wvalid = 1'b0;
        #1;
        chk("postrst_state", 32'(dbg_state), 32'd0);
        chk("postrst_wready", 32'(wready), 32'd0);
        chk("postrst_bvalid", 32'(bvalid), 32'd0);

        wbuf[0] = 32'hCAFEF00D; sbuf[0] = 4'hF;
        axi_write(32'h60, 8'd0, 2'b01, 4'd3, 1, 0, 1'b0);
        axi_read(32'h60, 8'd0, 2'b01, 4'd3, -1);
        axi_read(32'h20, 8'd0, 2'b01, 4'd0, -1);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
